// File: rtl/rect_fill_engine_if.sv
// rect_fill_engine_if: fill request, video-RAM write port and status between a host and the fill engine.
interface rect_fill_engine_if;
    logic        iStart;
    logic [7:0]  iXi;
    logic [7:0]  iYi;
    logic [7:0]  iXf;
    logic [7:0]  iYf;
    logic [2:0]  iColor;
    logic        iWrGrant;
    logic        oWrEn;
    logic [12:0] oWrAddr;
    logic [2:0]  oWrData;
    logic        oBusy;
    logic        oDone;
    logic        oError;
    modport master (
        output iStart, iXi, iYi, iXf, iYf, iColor, iWrGrant,
        input  oWrEn, oWrAddr, oWrData, oBusy, oDone, oError
    );
    modport slave (
        input  iStart, iXi, iYi, iXf, iYf, iColor, iWrGrant,
        output oWrEn, oWrAddr, oWrData, oBusy, oDone, oError
    );
endinterface

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: validates a rectangle and writes its pixels row-major into video RAM, one per granted cycle.
module rect_fill_engine #(
    parameter int H_RES = 80,
    parameter int V_RES = 60
) (
    input logic Clock,
    input logic Reset,
    rect_fill_engine_if.slave bus
);
    localparam logic [12:0] HW = 13'(H_RES);
    typedef enum logic [1:0] {IDLE, CHECK, FILL, DONE} state_t;
    state_t      state;
    logic [7:0]  xi, yi, xf, yf, x, y;
    logic [2:0]  color;
    logic [12:0] row_base;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            bus.oWrEn   <= 1'b0;
            bus.oWrAddr <= '0;
            bus.oWrData <= '0;
            bus.oBusy   <= 1'b0;
            bus.oDone   <= 1'b0;
            bus.oError  <= 1'b0;
        end else begin
            bus.oDone  <= 1'b0;
            bus.oError <= 1'b0;
            case (state)
                IDLE: if (bus.iStart) begin
                    xi        <= bus.iXi;
                    yi        <= bus.iYi;
                    xf        <= bus.iXf;
                    yf        <= bus.iYf;
                    color     <= bus.iColor;
                    bus.oBusy <= 1'b1;
                    state     <= CHECK;
                end
                CHECK: if (xi > xf || yi > yf || int'(xf) >= H_RES || int'(yf) >= V_RES) begin
                    bus.oError <= 1'b1;
                    bus.oBusy  <= 1'b0;
                    state      <= IDLE;
                end else begin
                    x           <= xi;
                    y           <= yi;
                    row_base    <= 13'(yi) * HW;
                    bus.oWrAddr <= 13'(yi) * HW + 13'(xi);
                    bus.oWrData <= color;
                    bus.oWrEn   <= 1'b1;
                    state       <= FILL;
                end
                // address advances incrementally; row_base avoids a multiplier in the scan loop
                FILL: if (bus.iWrGrant) begin
                    if (x < xf) begin
                        x           <= x + 8'd1;
                        bus.oWrAddr <= bus.oWrAddr + 13'd1;
                    end else if (y < yf) begin
                        x           <= xi;
                        y           <= y + 8'd1;
                        row_base    <= row_base + HW;
                        bus.oWrAddr <= row_base + HW + 13'(xi);
                    end else begin
                        bus.oWrEn <= 1'b0;
                        bus.oDone <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    bus.oBusy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed fills checked against a queue of expected pixel addresses built from the rectangle.
module tb_rect_fill_engine;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;
    rect_fill_engine_if bus();
    rect_fill_engine #(.H_RES(80), .V_RES(60)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
    int cmp = 0, bad = 0, writes = 0, dones = 0, errs = 0, last_addr = -1;
    int expected_q[$];
    logic [2:0] exp_color = '0;
    bit toggle = 0;
    bit prev_wr = 0;
    task automatic check(string name, int act, int req);
        cmp++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask
    // model: a request is either rejected or expands to its row-major list of y*80+x addresses
    task automatic request(int xi, int yi, int xf, int yf, logic [2:0] c);
        if (xi <= xf && yi <= yf && xf < 80 && yf < 60) begin
            exp_color = c;
            for (int yy = yi; yy <= yf; yy++)
                for (int xx = xi; xx <= xf; xx++)
                    expected_q.push_back(yy * 80 + xx);
        end
        bus.iStart = 1'b1;
        bus.iXi = 8'(xi); bus.iYi = 8'(yi); bus.iXf = 8'(xf); bus.iYf = 8'(yf);
        bus.iColor = c;
        @(posedge Clock); #1;
        bus.iStart = 1'b0;
    endtask
    task automatic wait_idle(int budget);
        int n = 0;
        while (bus.oBusy && n < budget) begin
            @(posedge Clock); #1;
            n++;
        end
        check("idle_timeout", int'(bus.oBusy), 0);
        check("queue_drained", expected_q.size(), 0);
    endtask
    always @(negedge Clock) begin
        if (Reset) begin
            expected_q.delete();
            prev_wr = 0;
        end else begin
            if (bus.oWrEn) begin
                check("wr_expected", int'(expected_q.size() > 0), 1);
                if (expected_q.size() > 0) begin
                    check("wr_addr", int'(bus.oWrAddr), expected_q[0]);
                    check("wr_data", int'(bus.oWrData), int'(exp_color));
                end
                check("busy_while_writing", int'(bus.oBusy), 1);
                if (bus.iWrGrant) begin
                    if (expected_q.size() > 0) void'(expected_q.pop_front());
                    writes++;
                    last_addr = int'(bus.oWrAddr);
                end
            end
            if (bus.oDone) begin
                dones++;
                check("done_after_last_write", int'(prev_wr && expected_q.size() == 0), 1);
                check("done_wren", int'(bus.oWrEn), 0);
            end
            if (bus.oError) begin
                errs++;
                check("error_wren", int'(bus.oWrEn), 0);
            end
            prev_wr = bus.oWrEn && bus.iWrGrant;
        end
    end
    initial begin
        bus.iWrGrant = 1'b1;
        forever begin
            @(posedge Clock); #1;
            bus.iWrGrant = toggle ? ~bus.iWrGrant : 1'b1;
        end
    end
    initial begin
        int w0, d0, e0;
        int bxf[3] = '{5, 80, 20};
        int byf[3] = '{0, 0, 60};
        bus.iStart = 1'b0;
        bus.iXi = '0; bus.iYi = '0; bus.iXf = '0; bus.iYf = '0; bus.iColor = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_wren", int'(bus.oWrEn), 0);
        check("rst_addr", int'(bus.oWrAddr), 0);
        check("rst_data", int'(bus.oWrData), 0);
        check("rst_busy", int'(bus.oBusy), 0);
        check("rst_done", int'(bus.oDone), 0);
        check("rst_error", int'(bus.oError), 0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        w0 = writes; d0 = dones;
        request(0, 0, 6, 6, 3'b100);
        check("t1_check_wren", int'(bus.oWrEn), 0);
        check("t1_check_busy", int'(bus.oBusy), 1);
        @(posedge Clock); #1;
        check("t1_first_wren", int'(bus.oWrEn), 1);
        check("t1_first_addr", int'(bus.oWrAddr), 0);
        wait_idle(200);
        check("t1_writes", writes - w0, 49);
        check("t1_last_addr", last_addr, 486);
        check("t1_dones", dones - d0, 1);

        w0 = writes; d0 = dones;
        toggle = 1;
        request(14, 0, 20, 6, 3'b011);
        wait_idle(400);
        toggle = 0;
        check("t2_writes", writes - w0, 49);
        check("t2_last_addr", last_addr, 500);
        check("t2_dones", dones - d0, 1);

        w0 = writes; d0 = dones;
        request(0, 0, 79, 59, 3'b111);
        wait_idle(6000);
        check("t3_writes", writes - w0, 4800);
        check("t3_last_addr", last_addr, 4799);
        check("t3_dones", dones - d0, 1);

        for (int i = 0; i < 3; i++) begin
            w0 = writes; e0 = errs;
            request(10, 0, bxf[i], byf[i], 3'b101);
            check("t4_busy_in_check", int'(bus.oBusy), 1);
            check("t4_error_early", int'(bus.oError), 0);
            @(posedge Clock); #1;
            check("t4_error_pulse", int'(bus.oError), 1);
            check("t4_busy_released", int'(bus.oBusy), 0);
            @(posedge Clock); #1;
            check("t4_error_one_cycle", int'(bus.oError), 0);
            check("t4_errors", errs - e0, 1);
            check("t4_writes", writes - w0, 0);
        end

        w0 = writes; d0 = dones;
        request(5, 5, 5, 5, 3'b010);
        @(posedge Clock); #1;
        check("t5_wren", int'(bus.oWrEn), 1);
        check("t5_addr", int'(bus.oWrAddr), 405);
        bus.iStart = 1'b1;
        bus.iXi = 8'd0; bus.iYi = 8'd0; bus.iXf = 8'd3; bus.iYf = 8'd3;
        @(posedge Clock); #1;
        bus.iStart = 1'b0;
        wait_idle(20);
        repeat (4) @(posedge Clock);
        #1;
        check("t5_second_start_ignored", int'(bus.oBusy), 0);
        check("t5_writes", writes - w0, 1);
        check("t5_last_addr", last_addr, 405);
        check("t5_dones", dones - d0, 1);

        w0 = writes; d0 = dones;
        request(0, 0, 79, 59, 3'b001);
        begin
            int n = 0;
            while (writes - w0 < 10 && n < 100) begin
                @(posedge Clock); #1;
                n++;
            end
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("t6_wren_after_reset", int'(bus.oWrEn), 0);
        check("t6_busy_after_reset", int'(bus.oBusy), 0);
        check("t6_addr_after_reset", int'(bus.oWrAddr), 0);
        repeat (10) @(posedge Clock);
        #1;
        check("t6_writes", writes - w0, 10);
        check("t6_no_done", dones - d0, 0);
        w0 = writes; d0 = dones;
        request(2, 3, 4, 4, 3'b110);
        wait_idle(100);
        check("t6_fresh_writes", writes - w0, 6);
        check("t6_fresh_last_addr", last_addr, 324);
        check("t6_fresh_dones", dones - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter H_RES, default 80, meaning screen width in pixels.
REQ-002 SHALL have parameter V_RES, default 60, meaning screen height in pixels.
REQ-003 SHALL have port Clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port iStart, input, 1, one-cycle fill request.
REQ-006 SHALL have ports iXi, iYi, iXf, iYf, input, 8 each, inclusive rectangle corners.
REQ-007 SHALL have port iColor, input, 3, pixel colour {R,G,B}.
REQ-008 SHALL have port iWrGrant, input, 1, video-RAM write port granted this cycle.
REQ-009 SHALL have port oWrEn, output, 1, pixel write request.
REQ-010 SHALL have port oWrAddr, output, 13, video-RAM address = y*H_RES + x.
REQ-011 SHALL have port oWrData, output, 3, colour being written.
REQ-012 SHALL have ports oBusy, oDone, oError, output, 1 each: operation active; one-cycle completion pulse; one-cycle rejection pulse.

Function
REQ-013 SHALL implement states IDLE, CHECK, FILL, DONE.
REQ-014 In IDLE, iStart=1 SHALL latch iXi, iYi, iXf, iYf, iColor and go to CHECK; iStart=0 stays IDLE.
REQ-015 CHECK SHALL reject when Xi>Xf, Yi>Yf, Xf>=H_RES or Yf>=V_RES: pulse oError one cycle, return to IDLE, issue no write.
REQ-016 CHECK otherwise SHALL set x=Xi, y=Yi and go to FILL; first oWrEn is therefore 2 cycles after iStart.
REQ-017 In FILL, oWrEn SHALL be 1 with oWrAddr=y*H_RES+x and oWrData=latched colour.
REQ-018 A write SHALL complete only on a cycle with oWrEn=1 and iWrGrant=1; otherwise oWrAddr/oWrData SHALL hold stable.
REQ-019 On a completed write, x<Xf SHALL give x+1; x=Xf with y<Yf SHALL give x=Xi, y+1; x=Xf with y=Yf SHALL go to DONE.
REQ-020 Scan order SHALL be row-major, left to right, top to bottom; each pixel written exactly once; (Xf-Xi+1)*(Yf-Yi+1) writes total.
REQ-021 DONE SHALL pulse oDone for one cycle with oWrEn=0, then return to IDLE.
REQ-022 oBusy SHALL be 1 in CHECK, FILL and DONE, 0 in IDLE.
REQ-023 iStart while oBusy=1 SHALL be ignored; latched parameters SHALL not change mid-operation.
REQ-024 Address arithmetic SHALL be 13-bit unsigned without overflow for all accepted rectangles (max 4799 at defaults).
REQ-025 Single-pixel (Xi=Xf, Yi=Yf) SHALL produce exactly one write then DONE.
REQ-026 iStart in the same cycle as oDone SHALL be ignored; a new request is accepted only in IDLE.
REQ-027 oWrEn SHALL be 0 in IDLE, CHECK and DONE.

Reset
REQ-028 Reset=1 SHALL force IDLE and oWrEn=0, oWrAddr=0, oWrData=0, oBusy=0, oDone=0, oError=0 on the next clock edge.
REQ-029 Reset asserted mid-FILL SHALL abort the fill with no further writes and no oDone pulse.
REQ-030 Reset SHALL take priority over iStart and iWrGrant in the same cycle.

Verification
REQ-031 Rectangle (0,0)-(6,6), colour 3'b100, iWrGrant=1 -> 49 writes, addresses 0..6, 80..86, ..., 480..486; oDone 1 cycle after the last write.
REQ-032 Rectangle (14,0)-(20,6) with iWrGrant toggling 1,0,1,0 -> 49 writes in order; address/data held through every denied cycle; no pixel duplicated or skipped.
REQ-033 (0,0)-(79,59) colour 3'b111 -> 4800 writes, last address 4799, single oDone pulse.
REQ-034 Inputs Xi=10, Xf=5, then Xf=80, then Yf=60 -> oError pulse each time, zero writes, oBusy back to 0 after 2 cycles.
REQ-035 Start (5,5)-(5,5), then second iStart asserted during FILL -> exactly one write at address 405; second iStart ignored.
REQ-036 Reset after 10 writes of (0,0)-(79,59) -> oWrEn=0 next cycle, no oDone; fresh iStart afterward runs normally.
